// File: rtl/ustc_pkg.sv
// Shared constants, line layout, FSM states and output narrowing for the
// unstructured sparse tensor core partial-sum accumulator.
package ustc_pkg;

   localparam int M        = 16;
   localparam int N        = 16;
   localparam int TILE_M   = 4;
   localparam int TILE_K   = 8;
   localparam int NUM_IN   = TILE_M * TILE_K;
   localparam int TILE_N   = 4;
   localparam int DW_DATA  = 32;
   localparam int DW_ACC   = 40;
   localparam int DW_POS   = 4;
   localparam int DW_CTRL  = 4;
   localparam bit SAT      = 1'b1;
   localparam int DW_LINE  = TILE_N * DW_DATA + DW_POS + DW_CTRL;

   // Line layout is {ctrl, row, data[TILE_N]} from MSB to LSB.
   localparam int OFF_ROW  = TILE_N * DW_DATA;
   localparam int OFF_CTRL = OFF_ROW + DW_POS;
   localparam int CTRL_VLD = DW_CTRL - 2;
   localparam int TN_W     = $clog2(TILE_N);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_DRAIN
   } state_t;

   // Narrow an accumulator value to the output width, clamping when sat=1.
   function automatic logic [DW_DATA-1:0] f_narrow(input logic signed [DW_ACC-1:0] v,
                                                   input bit sat);
      logic [DW_DATA-1:0] r;
      r = v[DW_DATA-1:0];
      if (sat && (v[DW_ACC-1:DW_DATA-1] != {(DW_ACC-DW_DATA+1){v[DW_ACC-1]}}))
         r = v[DW_ACC-1] ? {1'b1, {(DW_DATA-1){1'b0}}} : {1'b0, {(DW_DATA-1){1'b1}}};
      return r;
   endfunction

endpackage

// File: rtl/ustc_psum_acc_if.sv
// Input-beat, control and drain-stream signals of the partial-sum accumulator.
interface ustc_psum_acc_if;
   import ustc_pkg::*;

   logic                      in_valid;
   logic                      in_ready;
   logic [DW_POS-1:0]         col;
   logic [NUM_IN*DW_LINE-1:0] in;
   logic                      acc_mode;
   logic                      flush;
   logic                      keep;
   logic                      out_valid;
   logic                      out_ready;
   logic [DW_POS-1:0]         out_row;
   logic [N*DW_DATA-1:0]      out;
   logic                      busy;

   modport slave (
      input  in_valid, col, in, acc_mode, flush, keep, out_ready,
      output in_ready, out_valid, out_row, out, busy
   );

   modport master (
      output in_valid, col, in, acc_mode, flush, keep, out_ready,
      input  in_ready, out_valid, out_row, out, busy
   );

endinterface

// File: rtl/ustc_row_reduce.sv
// Per-row, per-lane sum of all valid input lines that target each row.
module ustc_row_reduce
   import ustc_pkg::*;
(
   input  logic [NUM_IN*DW_LINE-1:0] i_lines,
   output logic signed [DW_ACC-1:0]  o_sum [M][TILE_N]
);

   // Sum sign-extended lanes of every valid line whose row matches
   always_comb begin
      logic [DW_LINE-1:0]        w_line;
      logic signed [DW_ACC-1:0]  w_s;
      for (int r = 0; r < M; r++) begin
         for (int j = 0; j < TILE_N; j++) begin
            w_s = '0;
            for (int i = 0; i < NUM_IN; i++) begin
               w_line = i_lines[i*DW_LINE +: DW_LINE];
               if (w_line[OFF_CTRL+CTRL_VLD] && (int'(w_line[OFF_ROW +: DW_POS]) == r))
                  w_s = w_s + {{(DW_ACC-DW_DATA){w_line[j*DW_DATA+DW_DATA-1]}},
                               w_line[j*DW_DATA +: DW_DATA]};
            end
            o_sum[r][j] = w_s;
         end
      end
   end

endmodule

// File: rtl/ustc_psum_acc.sv
// Partial-sum accumulator: gathers a column tile, commits it into the M x N
// cache (overwrite or accumulate) and drains the cache row by row on flush.
module ustc_psum_acc
   import ustc_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   ustc_psum_acc_if.slave  bus
);

   state_t                   r_state, w_next;
   logic signed [DW_ACC-1:0] r_add       [M][TILE_N];
   logic signed [DW_ACC-1:0] w_contrib   [M][TILE_N];
   logic signed [DW_ACC-1:0] w_open_add  [M][TILE_N];
   logic signed [DW_ACC-1:0] r_cache     [M][N];
   logic signed [DW_ACC-1:0] w_cache_nxt [M][N];
   logic [DW_POS-1:0]        r_col, w_open_col, r_cnt;
   logic                     r_keep;
   logic                     w_acc, w_split, w_flush_go, w_cmt_b, w_pop, w_last;
   logic                     w_in_ready, w_out_valid, w_busy;
   logic [N*DW_DATA-1:0]     w_out;

   ustc_row_reduce u_reduce (
      .i_lines (bus.in),
      .o_sum   (w_contrib)
   );

   assign w_acc      = bus.in_valid & (r_state != ST_DRAIN);
   assign w_split    = (r_state == ST_ACCUM) & w_acc & (bus.col != r_col);
   assign w_flush_go = bus.flush & (r_state != ST_DRAIN);
   // A flush commits only when a tile is open or arrives on this very edge.
   assign w_cmt_b    = w_flush_go & ((r_state == ST_ACCUM) | w_acc);
   assign w_open_col = w_acc ? bus.col : r_col;
   assign w_pop      = (r_state == ST_DRAIN) & bus.out_ready;
   assign w_last     = (r_cnt == DW_POS'(M-1));

   // Next state and handshake outputs
   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b1;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_flush_go)  w_next = ST_DRAIN;
            else if (w_acc)  w_next = ST_ACCUM;
         end
         ST_ACCUM: begin
            w_busy = 1'b1;
            if (w_flush_go) w_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b1;
            w_busy      = 1'b1;
            if (w_pop && w_last) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Tile as it stands after folding in the current beat
   always_comb begin
      for (int r = 0; r < M; r++)
         for (int j = 0; j < TILE_N; j++)
            w_open_add[r][j] = w_split ? w_contrib[r][j] :
                               (w_acc ? r_add[r][j] + w_contrib[r][j] : r_add[r][j]);
   end

   // Apply the column-change commit, then the flush commit, then drain clearing
   always_comb begin
      logic signed [DW_ACC-1:0] v;
      logic [DW_POS-1:0]        la, lb;
      for (int r = 0; r < M; r++) begin
         for (int c = 0; c < N; c++) begin
            v  = r_cache[r][c];
            la = DW_POS'(c) - r_col;
            lb = DW_POS'(c) - w_open_col;
            if (w_split && (DW_POS'(c) >= r_col) && (la < DW_POS'(TILE_N)))
               v = bus.acc_mode ? v + r_add[r][la[TN_W-1:0]] : r_add[r][la[TN_W-1:0]];
            if (w_cmt_b && (DW_POS'(c) >= w_open_col) && (lb < DW_POS'(TILE_N)))
               v = bus.acc_mode ? v + w_open_add[r][lb[TN_W-1:0]] : w_open_add[r][lb[TN_W-1:0]];
            if (w_pop && !r_keep && (DW_POS'(r) == r_cnt))
               v = '0;
            w_cache_nxt[r][c] = v;
         end
      end
   end

   // Result cache register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
               r_cache[r][c] <= '0;
      end else begin
         r_cache <= w_cache_nxt;
      end
   end

   // Open tile accumulator and its base column
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < M; r++)
            for (int j = 0; j < TILE_N; j++)
               r_add[r][j] <= '0;
         r_col <= '0;
      end else begin
         if (w_flush_go) begin
            for (int r = 0; r < M; r++)
               for (int j = 0; j < TILE_N; j++)
                  r_add[r][j] <= '0;
         end else if (w_acc) begin
            r_add <= w_open_add;
         end
         if (w_acc) r_col <= bus.col;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // Drain row counter and retain flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_keep <= 1'b0;
      end else if (w_flush_go) begin
         r_cnt  <= '0;
         r_keep <= bus.keep;
      end else if (w_pop) begin
         r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Drain row narrowed to the output width
   always_comb begin
      w_out = '0;
      if (r_state == ST_DRAIN)
         for (int c = 0; c < N; c++)
            w_out[c*DW_DATA +: DW_DATA] = f_narrow(r_cache[r_cnt][c], SAT);
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.busy      = w_busy;
   assign bus.out_row   = r_cnt;
   assign bus.out       = w_out;

endmodule

// File: tb/tb_ustc_psum_acc.sv
// Directed bench for the partial-sum accumulator with hand-computed results.
module tb_ustc_psum_acc;
   import ustc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [N*DW_DATA-1:0] exp_row [M];

   always #5 clk = ~clk;

   ustc_psum_acc_if bus ();

   ustc_psum_acc dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [N*DW_DATA-1:0] obs,
                      input logic [N*DW_DATA-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clr_lines();
      bus.in = '0;
   endtask

   task automatic set_line(input int idx, input logic [DW_POS-1:0] row, input logic vld,
                           input logic [31:0] l0, input logic [31:0] l1,
                           input logic [31:0] l2, input logic [31:0] l3);
      bus.in[idx*DW_LINE +: DW_LINE] = {1'b0, vld, 2'b00, row, l3, l2, l1, l0};
   endtask

   task automatic clr_exp();
      for (int r = 0; r < M; r++) exp_row[r] = '0;
   endtask

   task automatic set_exp(input int r, input int c, input logic [31:0] v);
      exp_row[r][c*DW_DATA +: DW_DATA] = v;
   endtask

   task automatic beat(input logic [DW_POS-1:0] c, input logic fl, input logic kp,
                       input logic am);
      chk("in_ready_before_beat", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.col      = c;
      bus.flush    = fl;
      bus.keep     = kp;
      bus.acc_mode = am;
      step();
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      clr_lines();
   endtask

   task automatic flush_only(input logic kp, input logic am);
      bus.flush    = 1'b1;
      bus.keep     = kp;
      bus.acc_mode = am;
      step();
      bus.flush    = 1'b0;
   endtask

   task automatic drain_rows(input string tag, input int nrows, input int stall_rows);
      for (int r = 0; r < nrows; r++) begin
         chk($sformatf("%s_vld%0d", tag, r), bus.out_valid, 1);
         chk($sformatf("%s_row%0d", tag, r), bus.out_row, r);
         chk($sformatf("%s_dat%0d", tag, r), bus.out, exp_row[r]);
         if (r < stall_rows) begin
            bus.out_ready = 1'b0;
            step();
            step();
            chk($sformatf("%s_hold_row%0d", tag, r), bus.out_row, r);
            chk($sformatf("%s_hold_dat%0d", tag, r), bus.out, exp_row[r]);
            bus.out_ready = 1'b1;
         end
         step();
      end
   endtask

   task automatic drain(input string tag, input int stall_rows);
      drain_rows(tag, M, stall_rows);
      chk({tag, "_end_in_ready"}, bus.in_ready, 1);
      chk({tag, "_end_busy"}, bus.busy, 0);
      chk({tag, "_end_out_valid"}, bus.out_valid, 0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.col       = '0;
      bus.in        = '0;
      bus.acc_mode  = 1'b0;
      bus.flush     = 1'b0;
      bus.keep      = 1'b0;
      bus.out_ready = 1'b1;
      rst = 1'b0;
      step();
      step();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_row", bus.out_row, 0);
      chk("rst_out", bus.out, 0);
      chk("rst_busy", bus.busy, 0);
      rst = 1'b1;
      step();

      // single beat then flush, cache cleared afterwards
      clr_lines();
      set_line(0, 4'd2, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4);
      beat(4'd0, 1'b0, 1'b0, 1'b0);
      chk("t1_busy_accum", bus.busy, 1);
      chk("t1_no_out_valid", bus.out_valid, 0);
      flush_only(1'b0, 1'b0);
      clr_exp();
      set_exp(2, 0, 32'd1); set_exp(2, 1, 32'd2); set_exp(2, 2, 32'd3); set_exp(2, 3, 32'd4);
      drain("t1", 0);
      flush_only(1'b0, 1'b0);
      clr_exp();
      drain("t1_zero", 0);

      // two lines to the same row summed, invalid line ignored, flush with beat
      clr_lines();
      set_line(0, 4'd5, 1'b1, 32'd10, 32'd0, 32'd0, 32'd0);
      set_line(7, 4'd5, 1'b1, 32'd7, 32'd0, 32'd0, 32'd0);
      set_line(3, 4'd3, 1'b0, 32'd99, 32'd99, 32'd99, 32'd99);
      beat(4'd0, 1'b1, 1'b0, 1'b0);
      clr_exp();
      set_exp(5, 0, 32'd17);
      drain("t2", 0);

      // back-to-back tiles, re-accumulate within a tile, column change with flush
      set_line(0, 4'd1, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4);
      beat(4'd0, 1'b0, 1'b0, 1'b0);
      set_line(0, 4'd1, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8);
      beat(4'd4, 1'b0, 1'b0, 1'b0);
      set_line(0, 4'd1, 1'b1, 32'd1, 32'd1, 32'd1, 32'd1);
      beat(4'd4, 1'b0, 1'b0, 1'b0);
      set_line(0, 4'd1, 1'b1, 32'd20, 32'd0, 32'd0, 32'd0);
      beat(4'd8, 1'b1, 1'b0, 1'b0);
      clr_exp();
      set_exp(1, 0, 32'd1); set_exp(1, 1, 32'd2); set_exp(1, 2, 32'd3); set_exp(1, 3, 32'd4);
      set_exp(1, 4, 32'd6); set_exp(1, 5, 32'd7); set_exp(1, 6, 32'd8); set_exp(1, 7, 32'd9);
      set_exp(1, 8, 32'd20);
      drain("t3", 0);

      // accumulate across passes with keep, then overwrite
      set_line(0, 4'd1, 1'b1, 32'd0, 32'd3, 32'd0, 32'd0);
      beat(4'd0, 1'b1, 1'b1, 1'b1);
      clr_exp();
      set_exp(1, 1, 32'd3);
      drain("t4a", 0);
      set_line(0, 4'd1, 1'b1, 32'd0, 32'd3, 32'd0, 32'd0);
      beat(4'd0, 1'b1, 1'b1, 1'b1);
      set_exp(1, 1, 32'd6);
      drain("t4b", 0);
      set_line(0, 4'd1, 1'b1, 32'd0, 32'd5, 32'd0, 32'd0);
      beat(4'd0, 1'b1, 1'b0, 1'b0);
      set_exp(1, 1, 32'd5);
      drain("t4c", 0);

      // tile straddling the right edge: out-of-range lanes dropped, no wrap
      set_line(0, 4'd0, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4);
      beat(4'd14, 1'b1, 1'b0, 1'b0);
      clr_exp();
      set_exp(0, 14, 32'd1); set_exp(0, 15, 32'd2);
      drain("t5", 0);

      // saturation, stalled drain, then reset mid-drain
      for (int i = 0; i < 8; i++)
         set_line(i, 4'd3, 1'b1, 32'h4000_0000, 32'h8000_0000,
                  (i == 0) ? 32'hFFFF_FFFB : 32'h0, 32'h0);
      beat(4'd0, 1'b1, 1'b1, 1'b0);
      clr_exp();
      set_exp(3, 0, 32'h7FFF_FFFF); set_exp(3, 1, 32'h8000_0000); set_exp(3, 2, 32'hFFFF_FFFB);
      drain_rows("t6", 6, 4);
      rst = 1'b0;
      #1;
      chk("t6_rst_out_valid", bus.out_valid, 0);
      chk("t6_rst_busy", bus.busy, 0);
      chk("t6_rst_in_ready", bus.in_ready, 1);
      chk("t6_rst_out_row", bus.out_row, 0);
      step();
      rst = 1'b1;
      step();
      flush_only(1'b0, 1'b0);
      clr_exp();
      drain("t6_zero", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ustc_psum_acc.md
# ustc_psum_acc

Next-generation partial-sum accumulator for the unstructured sparse tensor core. Collects per-row partial products from the TILE_M×TILE_K multiplier array for a TILE_N-wide column tile and commits each finished tile into an M×N result cache, either overwriting it or accumulating across K passes. When a flush is issued, the cache drains as a row-serial valid/ready stream instead of one flat M·N bus. Sits between the sparse multiplier array and the output writeback.

## Interface
- M, 16, output rows
- N, 16, output columns
- TILE_M, 4, multiplier tile rows
- TILE_K, 8, multiplier tile depth; NUM_IN = TILE_M*TILE_K input lines
- TILE_N, 4, columns per input line
- DW_DATA, 32, output element width
- DW_ACC, 40, accumulator/cache element width (≥ DW_DATA)
- DW_POS, 4, row/column index width (≥ clog2(max(M,N)))
- DW_CTRL, 4, per-line control width; bit DW_CTRL-2 = line valid
- SAT, 1, 1 = saturate on output narrowing, 0 = truncate
- DW_LINE, TILE_N*DW_DATA+DW_POS+DW_CTRL, line layout {ctrl, row, data[TILE_N]}, lane j at data[j*DW_DATA +: DW_DATA], signed

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat
- col  in  DW_POS  first column of the beat's tile
- in  in  NUM_IN*DW_LINE  packed input lines
- acc_mode  in  1  0 = commit overwrites cache, 1 = commit adds to cache
- flush  in  1  pulse: end of pass, commit open tile and drain
- keep  in  1  sampled with flush: 1 = retain cache after drain, 0 = zero it
- out_valid  out  1  drain beat present
- out_ready  in  1  consumer accepts drain beat
- out_row  out  DW_POS  row index of drain beat
- out  out  N*DW_DATA  row data, column c at [c*DW_DATA +: DW_DATA]
- busy  out  1  high in ACCUM and DRAIN

## Operation
- States: IDLE, ACCUM, DRAIN. Reset → IDLE; cache, reg_add, reg_col zero.
- in_ready = 1 in IDLE/ACCUM, 0 in DRAIN. Accepted beat = in_valid & in_ready.
- IDLE + accepted beat: reg_col←col, reg_add←beat contributions, → ACCUM.
- ACCUM + accepted beat, col == reg_col: reg_add[r][j] += sum of lane j of all valid lines with row r. Multiple lines targeting the same row in one beat are all summed (no last-write-wins).
- ACCUM + accepted beat, col != reg_col: same edge commits reg_add to cache columns reg_col+j, then reg_add←this beat's contributions, reg_col←col. No stall.
- Commit: cache[r][reg_col+j] ← reg_add[r][j] (acc_mode=0) or cache+reg_add (acc_mode=1). Lanes with reg_col+j ≥ N are discarded (no wrap). acc_mode sampled at commit edge.
- Lines with valid bit 0 or row ≥ M are ignored.
- flush (IDLE or ACCUM): if also beat accepted, beat is folded in first (same rules), then open tile committed at that edge; reg_add cleared; keep latched; → DRAIN, row counter 0. flush in IDLE with no open tile commits nothing and drains.
- DRAIN: out_valid=1, out_row=counter, out = cache row narrowed to DW_DATA (signed saturate if SAT else low bits). On out_valid & out_ready: counter++, and row zeroed if keep=0. Beat M-1 accepted → IDLE.
- flush in DRAIN ignored.
- Accumulator arithmetic: DW_ACC two's complement, wraps on overflow; inputs sign-extended.

## Timing
- Reset values: in_ready=1, out_valid=0, out_row=0, out=0, busy=0.
- Contributions visible in reg_add one edge after acceptance; committed tile visible in cache at the commit edge.
- flush accepted at edge t → out_valid=1, out_row=0 in cycle after t; one row per cycle with out_ready held high; last row M cycles after t; in_ready=1 the cycle after row M-1 accepted.
- out/out_row stable while out_valid & !out_ready.
- rst asserted mid-operation: immediate return to IDLE, all state zero, in-flight tile lost.

## Structure
- Shared package ustc_pkg: DW_* constants, line field offsets, ctrl bit index, FSM state enum, saturating narrow function.
- Sub-module ustc_row_reduce: combinational per-row, per-lane sum of matching valid lines (NUM_IN inputs → M×TILE_N sums); top holds FSM, reg_add, cache, drain mux.

## Test plan
- Single beat col=0, line row 2 lanes {1,2,3,4}, flush keep=0 → drain row 2 = {1,2,3,4,0…}, others 0; cache zero afterwards.
- Two lines same row 5 in one beat, lanes 10 and 7 → row 5 lanes = 17 (summed).
- Tiles col=0 then col=4 back-to-back, no stall → both committed; in_ready never drops before flush.
- acc_mode=1, two passes each writing 3 to cell (1,1), keep=1 between → drain shows 6.
- col=14, TILE_N=4, values {1,2,3,4} row 0 → columns 14,15 = 1,2; lanes 3,4 dropped.
- out_ready toggling during drain, SAT=1 with cell 2^33 → row held while stalled; cell reads 0x7FFFFFFF; rst low mid-drain → out_valid=0 next cycle, cache zero.
